psum_accum: RTL and testbench
=============================

PSUM_ACCUM -- requirements
Module: psum_accum

Interface
REQ-001 SHALL have parameter DATA_WID, default `CNN_XLEN, width of each incoming adder-tree sum and of the result.
REQ-002 SHALL have parameter ACC_WID, default DATA_WID+8, internal accumulator width.
REQ-003 SHALL have parameter CNT_WID, default 8, width of the group-count input.
REQ-004 SHALL have ports as follows; there is one clock, and reset is synchronous and active-high:
- clk  input  1  single clock; all state changes on posedge.
- reset  input  1  synchronous, active-high.
- status_in  input  PE_STATE  VALID marks data_in as a live partial sum.
- data_in  input  signed DATA_WID  one reduced sum from the upstream adder tree.
- grp_num  input  CNT_WID  number of sums per result; sampled only on a group's first beat.
- in_ready  output  1  combinational; high when a VALID beat will be consumed this cycle.
- out_ready  input  1  downstream accepts the result this cycle.
- status_out  output  PE_STATE  VALID while a result is held.
- data_out  output  signed DATA_WID  saturated accumulated result.
- drop_err  output  1  sticky; a VALID beat arrived while in_ready was low.

Function
REQ-005 SHALL implement the FSM states IDLE, ACCUM and HOLD.
REQ-006 SHALL set in_ready = (state != HOLD) || out_ready.
REQ-007 SHALL define a beat as consumed when status_in == VALID and in_ready == 1; any other status_in value SHALL be ignored.
REQ-008 IDLE, on a consumed beat: acc <= sign-extended data_in; cnt <= 1; tgt <= grp_num, or 1 when grp_num == 0. Next state is HOLD if tgt == 1, else ACCUM.
REQ-009 ACCUM, on a consumed beat: acc <= acc + sext(data_in); cnt <= cnt + 1. When cnt+1 == tgt, next state is HOLD. With no beat, ACCUM SHALL hold state with no timeout.
REQ-010 The result SHALL appear one cycle after the last contributing beat is consumed: status_out == VALID in HOLD, INVALID in every other state.
REQ-011 data_out SHALL equal acc clamped to the signed DATA_WID range, max 2^(DATA_WID-1)-1 and min -2^(DATA_WID-1). It SHALL be held stable throughout HOLD.
REQ-012 HOLD with out_ready == 0: state, acc and data_out SHALL be unchanged.
REQ-013 HOLD with out_ready == 1 and no consumed beat: next state IDLE.
REQ-014 HOLD with out_ready == 1 and a consumed beat: that beat SHALL start a new group exactly as in REQ-008 (back-to-back, no bubble).
REQ-015 The accumulator SHALL NOT wrap: ACC_WID must cover 2^CNT_WID sums; the add is full-width with no intermediate saturation.
REQ-016 A VALID beat with in_ready == 0 SHALL be discarded and SHALL set drop_err, which stays set until reset.
REQ-017 A change in grp_num mid-group SHALL have no effect on the current group.
REQ-018 All registered outputs SHALL be assigned with the `SD delay macro.

Reset
REQ-019 On reset == 1 at posedge clk: state <= IDLE, acc <= 0, cnt <= 0, tgt <= 0, status_out <= INVALID, data_out <= 0, drop_err <= 0.
REQ-020 Reset mid-group or in HOLD SHALL discard the partial or held result with no output beat. Inputs in the reset cycle are ignored.

Structure
REQ-021 PE_STATE (INVALID/VALID) and `CNN_XLEN, `ICP_NUM and `SD SHALL come from the existing shared header/package.
REQ-022 The FSM state enum (IDLE/ACCUM/HOLD) SHALL be added to that shared package.
REQ-023 A sub-module sat_clip (ACC_WID -> DATA_WID signed clamp, combinational) SHALL be used for REQ-011. Everything else stays in psum_accum.

Verification
REQ-024 With DATA_WID=16, grp_num=4 and beats 10, -3, 7, 100 on consecutive cycles, out_ready=1: status_out VALID with data_out=114 exactly one cycle after the 4th beat, then INVALID.
REQ-025 With grp_num=0 and a single beat of -5: result -5 after 1 cycle. grp_num=1 SHALL behave identically.
REQ-026 With grp_num=3, beats 30000 x3: data_out=32767. With beats -30000 x3: data_out=-32768.
REQ-027 Hold out_ready=0 for 5 cycles in HOLD and drive a VALID beat: in_ready=0, data_out stable, drop_err=1. Then drive out_ready=1 together with a VALID beat of 9 (grp_num=2): the next group starts with no bubble.
REQ-028 Assert reset in ACCUM after 2 of 4 beats, then send a fresh group of 1,1,1,1: the result is 4, not polluted by the earlier beats, and all outputs were at reset values during reset.
REQ-029 Random gaps of INVALID between beats with grp_num=8: the result equals the sum of the 8 VALID beats only.

Source files
------------

// File: rtl/psum_accum_pkg.sv
// ---------------------------------------------------------------------------
// Shared CNN datapath definitions used by the partial-sum accumulator.
//
// Provides:
//   `CNN_XLEN  - default datapath width of a PE sum
//   `ICP_NUM   - number of input-channel lanes feeding the adder tree
//   `SD        - delay placed on registered assignments; empty for synthesis
//   PE_STATE   - beat qualifier carried alongside data (INVALID/VALID)
//   psum_state_t - accumulator FSM states (IDLE/ACCUM/HOLD)
// ---------------------------------------------------------------------------
`ifndef CNN_XLEN
`define CNN_XLEN 16
`endif

`ifndef ICP_NUM
`define ICP_NUM 8
`endif

`ifndef SD
`define SD
`endif

package psum_accum_pkg;

  // Qualifier travelling with every data word between PE stages
  typedef enum logic {
    INVALID = 1'b0,
    VALID   = 1'b1
  } PE_STATE;

  // Accumulator FSM: waiting for a group, summing a group, presenting a result
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } psum_state_t;

endpackage

// File: rtl/psum_accum_sat_clip.sv
// ---------------------------------------------------------------------------
// sat_clip - combinational signed clamp from a wide accumulator to the
// narrower result width.
//
// Ports:
//   din   in   signed IN_WID   wide accumulator value
//   dout  out  signed OUT_WID  din clamped to [-2^(OUT_WID-1), 2^(OUT_WID-1)-1]
// ---------------------------------------------------------------------------
module sat_clip #(
  parameter int IN_WID  = 24,
  parameter int OUT_WID = 16
) (
  input  logic signed [IN_WID-1:0]  din,
  output logic signed [OUT_WID-1:0] dout
);

  // Output range limits expressed at input width so the compare is signed
  // and full-width.
  localparam logic signed [IN_WID-1:0] MAX_V =
    {{(IN_WID-OUT_WID+1){1'b0}}, {(OUT_WID-1){1'b1}}};
  localparam logic signed [IN_WID-1:0] MIN_V =
    {{(IN_WID-OUT_WID+1){1'b1}}, {(OUT_WID-1){1'b0}}};

  always_comb begin
    dout = din[OUT_WID-1:0];
    if (din > MAX_V) begin
      dout = MAX_V[OUT_WID-1:0];
    end else if (din < MIN_V) begin
      dout = MIN_V[OUT_WID-1:0];
    end
  end

endmodule

// File: rtl/psum_accum.sv
// ---------------------------------------------------------------------------
// psum_accum - accumulates groups of partial sums from an upstream adder
// tree and presents one saturated result per group with a ready handshake.
//
// Ports:
//   clk         in   1          single clock, posedge
//   reset       in   1          synchronous, active-high
//   status_in   in   PE_STATE   VALID marks data_in as a live partial sum
//   data_in     in   DATA_WID   signed partial sum
//   grp_num     in   CNT_WID    sums per result (0 treated as 1), sampled on
//                               the first beat of a group only
//   in_ready    out  1          a VALID beat is consumed this cycle
//   out_ready   in   1          downstream takes the held result this cycle
//   status_out  out  PE_STATE   VALID while a result is held
//   data_out    out  DATA_WID   saturated group sum
//   drop_err    out  1          sticky: a VALID beat arrived while not ready
// ---------------------------------------------------------------------------
module psum_accum
  import psum_accum_pkg::*;
#(
  parameter int DATA_WID = `CNN_XLEN,
  parameter int ACC_WID  = DATA_WID + 8,
  parameter int CNT_WID  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  PE_STATE                    status_in,
  input  logic signed [DATA_WID-1:0] data_in,
  input  logic [CNT_WID-1:0]         grp_num,
  output logic                       in_ready,
  input  logic                       out_ready,
  output PE_STATE                    status_out,
  output logic signed [DATA_WID-1:0] data_out,
  output logic                       drop_err
);

  psum_state_t               state;
  logic signed [ACC_WID-1:0] acc;
  logic signed [ACC_WID-1:0] acc_next;
  logic signed [ACC_WID-1:0] data_ext;
  logic signed [DATA_WID-1:0] clip_out;
  logic [CNT_WID-1:0]        cnt;
  logic [CNT_WID-1:0]        tgt;
  logic [CNT_WID-1:0]        start_tgt;
  logic                      beat;
  logic                      start;
  logic                      last;

  // A held result blocks new input unless downstream takes it in the same
  // cycle, which lets the next group start without a bubble.
  assign in_ready = (state != HOLD) || out_ready;
  assign beat     = (status_in == VALID) && in_ready;

  assign data_ext = {{(ACC_WID-DATA_WID){data_in[DATA_WID-1]}}, data_in};

  // Outside ACCUM any consumed beat opens a new group, so both the running
  // sum and the "is this the last beat" test depend on that distinction.
  always_comb begin
    start     = beat && (state != ACCUM);
    start_tgt = (grp_num == '0) ? CNT_WID'(1) : grp_num;
    acc_next  = start ? data_ext : (acc + data_ext);
    last      = start ? (start_tgt == CNT_WID'(1))
                      : ((cnt + CNT_WID'(1)) == tgt);
  end

  // Clamp the value the accumulator is about to take so the result can be
  // registered on the same edge as the final beat.
  sat_clip #(
    .IN_WID  (ACC_WID),
    .OUT_WID (DATA_WID)
  ) u_sat_clip (
    .din  (acc_next),
    .dout (clip_out)
  );

  // Single-process FSM with registered outputs. A consumed beat either
  // opens or extends a group; the last beat of a group moves to HOLD and
  // latches the clamped result. HOLD is left only through out_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= `SD IDLE;
      acc        <= `SD '0;
      cnt        <= `SD '0;
      tgt        <= `SD '0;
      status_out <= `SD INVALID;
      data_out   <= `SD '0;
      drop_err   <= `SD 1'b0;
    end else begin
      if ((status_in == VALID) && !in_ready) begin
        drop_err <= `SD 1'b1;
      end

      if (beat) begin
        acc <= `SD acc_next;
        if (start) begin
          cnt <= `SD CNT_WID'(1);
          tgt <= `SD start_tgt;
        end else begin
          cnt <= `SD cnt + CNT_WID'(1);
        end

        if (last) begin
          state      <= `SD HOLD;
          status_out <= `SD VALID;
          data_out   <= `SD clip_out;
        end else begin
          state      <= `SD ACCUM;
          status_out <= `SD INVALID;
        end
      end else if ((state == HOLD) && out_ready) begin
        state      <= `SD IDLE;
        status_out <= `SD INVALID;
      end
    end
  end

endmodule

// File: tb/tb_psum_accum.sv
// ---------------------------------------------------------------------------
// tb_psum_accum - self-checking bench for psum_accum (DATA_WID=16).
// Expected group results are pushed to a queue as the last beat of a group
// is driven and popped when the DUT presents the result.
// ---------------------------------------------------------------------------
module tb_psum_accum;
  import psum_accum_pkg::*;

  localparam int DW = 16;
  localparam int AW = 24;
  localparam int CW = 8;

  logic                 clk;
  logic                 reset;
  PE_STATE              status_in;
  logic signed [DW-1:0] data_in;
  logic [CW-1:0]        grp_num;
  logic                 in_ready;
  logic                 out_ready;
  PE_STATE              status_out;
  logic signed [DW-1:0] data_out;
  logic                 drop_err;

  int checks = 0;
  int errors = 0;
  logic signed [DW-1:0] exp_q[$];

  psum_accum #(
    .DATA_WID (DW),
    .ACC_WID  (AW),
    .CNT_WID  (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .status_in  (status_in),
    .data_in    (data_in),
    .grp_num    (grp_num),
    .in_ready   (in_ready),
    .out_ready  (out_ready),
    .status_out (status_out),
    .data_out   (data_out),
    .drop_err   (drop_err)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a stuck run
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one clock; inputs are driven and outputs sampled 1 ns after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input int v);
    status_in = VALID;
    data_in   = DW'(v);
  endtask

  task automatic drive_idle();
    status_in = INVALID;
    data_in   = '0;
  endtask

  task automatic test_reset();
    logic signed [DW-1:0] got;
    reset = 1'b1;
    drive_beat(123);
    out_ready = 1'b1;
    step();
    step();
    checks++;
    if (status_out !== INVALID) begin
      errors++;
      $display("[TB] FAIL reset_status: got %0d expected %0d", status_out, INVALID);
    end
    got = data_out;
    checks++;
    if (got !== 16'sd0) begin
      errors++;
      $display("[TB] FAIL reset_data: got %0d expected 0", got);
    end
    checks++;
    if (drop_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_drop_err: got %b expected 0", drop_err);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    reset = 1'b0;
    drive_idle();
    step();
  endtask

  task automatic test_basic();
    int beats[4] = '{10, -3, 7, 100};
    logic signed [DW-1:0] exp_v;
    out_ready = 1'b1;
    grp_num   = 8'd4;
    for (int k = 0; k < 4; k++) begin
      drive_beat(beats[k]);
      if (k == 3) exp_q.push_back(DW'(114));
      step();
      if (k < 3) begin
        checks++;
        if (status_out !== INVALID) begin
          errors++;
          $display("[TB] FAIL basic_early_valid: beat %0d got %0d expected %0d", k, status_out, INVALID);
        end
      end
    end
    drive_idle();
    exp_v = exp_q.pop_front();
    checks++;
    if (status_out !== VALID || data_out !== exp_v) begin
      errors++;
      $display("[TB] FAIL basic_result: got status %0d data %0d expected status 1 data %0d", status_out, data_out, exp_v);
    end
    step();
    checks++;
    if (status_out !== INVALID) begin
      errors++;
      $display("[TB] FAIL basic_release: got %0d expected %0d", status_out, INVALID);
    end
  endtask

  task automatic test_single();
    logic signed [DW-1:0] exp_v;
    out_ready = 1'b1;
    for (int g = 0; g < 2; g++) begin
      grp_num = CW'(g);
      drive_beat(-5);
      exp_q.push_back(-16'sd5);
      step();
      drive_idle();
      exp_v = exp_q.pop_front();
      checks++;
      if (status_out !== VALID || data_out !== exp_v) begin
        errors++;
        $display("[TB] FAIL single_grp%0d: got status %0d data %0d expected status 1 data %0d", g, status_out, data_out, exp_v);
      end
      step();
      checks++;
      if (status_out !== INVALID) begin
        errors++;
        $display("[TB] FAIL single_release_grp%0d: got %0d expected %0d", g, status_out, INVALID);
      end
    end
  endtask

  task automatic test_saturation();
    int vals[2] = '{30000, -30000};
    logic signed [DW-1:0] exps[2] = '{16'sh7FFF, 16'sh8000};
    logic signed [DW-1:0] exp_v;
    out_ready = 1'b1;
    grp_num   = 8'd3;
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 3; k++) begin
        drive_beat(vals[s]);
        if (k == 2) exp_q.push_back(exps[s]);
        step();
      end
      drive_idle();
      exp_v = exp_q.pop_front();
      checks++;
      if (status_out !== VALID || data_out !== exp_v) begin
        errors++;
        $display("[TB] FAIL saturation_%0d: got status %0d data %0d expected status 1 data %0d", s, status_out, data_out, exp_v);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    logic signed [DW-1:0] exp_v;
    out_ready = 1'b0;
    grp_num   = 8'd2;
    drive_beat(5);
    step();
    drive_beat(6);
    exp_q.push_back(DW'(11));
    step();
    drive_idle();
    exp_v = exp_q.pop_front();
    checks++;
    if (status_out !== VALID || data_out !== exp_v) begin
      errors++;
      $display("[TB] FAIL bp_result: got status %0d data %0d expected status 1 data %0d", status_out, data_out, exp_v);
    end
    for (int i = 0; i < 5; i++) begin
      if (i == 2) drive_beat(77);
      else drive_idle();
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_in_ready: cycle %0d got %b expected 0", i, in_ready);
      end
      step();
      checks++;
      if (status_out !== VALID || data_out !== exp_v) begin
        errors++;
        $display("[TB] FAIL bp_hold: cycle %0d got status %0d data %0d expected status 1 data %0d", i, status_out, data_out, exp_v);
      end
    end
    drive_idle();
    checks++;
    if (drop_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_drop_err: got %b expected 1", drop_err);
    end
    // Release the held result and start the next group on the same edge
    out_ready = 1'b1;
    grp_num   = 8'd2;
    drive_beat(9);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_release_ready: got %b expected 1", in_ready);
    end
    step();
    checks++;
    if (status_out !== INVALID) begin
      errors++;
      $display("[TB] FAIL bp_first_of_next: got %0d expected %0d", status_out, INVALID);
    end
    drive_beat(4);
    exp_q.push_back(DW'(13));
    step();
    drive_idle();
    exp_v = exp_q.pop_front();
    checks++;
    if (status_out !== VALID || data_out !== exp_v) begin
      errors++;
      $display("[TB] FAIL bp_next_group: got status %0d data %0d expected status 1 data %0d", status_out, data_out, exp_v);
    end
    step();
  endtask

  task automatic test_reset_mid();
    logic signed [DW-1:0] exp_v;
    out_ready = 1'b1;
    grp_num   = 8'd4;
    drive_beat(50);
    step();
    drive_beat(60);
    step();
    reset = 1'b1;
    drive_beat(999);
    step();
    checks++;
    if (status_out !== INVALID || data_out !== 16'sd0 || drop_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: got status %0d data %0d drop %b expected 0 0 0", status_out, data_out, drop_err);
    end
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_beat(1);
      if (k == 3) exp_q.push_back(DW'(4));
      step();
    end
    drive_idle();
    exp_v = exp_q.pop_front();
    checks++;
    if (status_out !== VALID || data_out !== exp_v) begin
      errors++;
      $display("[TB] FAIL midreset_fresh: got status %0d data %0d expected status 1 data %0d", status_out, data_out, exp_v);
    end
    step();
  endtask

  task automatic test_random_gaps();
    int sum;
    int v;
    logic signed [DW-1:0] exp_v;
    out_ready = 1'b1;
    for (int rep = 0; rep < 3; rep++) begin
      sum     = 0;
      grp_num = 8'd8;
      for (int k = 0; k < 8; k++) begin
        int gap;
        gap = $urandom_range(0, 3);
        drive_idle();
        for (int g = 0; g < gap; g++) step();
        v = int'($urandom_range(0, 4000)) - 2000;
        sum += v;
        drive_beat(v);
        if (k == 7) exp_q.push_back(DW'(sum));
        step();
        // Changing grp_num mid-group must not affect the group length
        grp_num = CW'($urandom_range(1, 255));
        if (k < 7) begin
          checks++;
          if (status_out !== INVALID) begin
            errors++;
            $display("[TB] FAIL gaps_early_valid: rep %0d beat %0d got %0d", rep, k, status_out);
          end
        end
      end
      drive_idle();
      exp_v = exp_q.pop_front();
      checks++;
      if (status_out !== VALID || data_out !== exp_v) begin
        errors++;
        $display("[TB] FAIL gaps_result: rep %0d got status %0d data %0d expected status 1 data %0d", rep, status_out, data_out, exp_v);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    int vals[4] = '{3, -7, 1000, -32768};
    logic signed [DW-1:0] exp_v;
    out_ready = 1'b1;
    grp_num   = 8'd1;
    for (int k = 0; k < 4; k++) begin
      drive_beat(vals[k]);
      exp_q.push_back(DW'(vals[k]));
      step();
      exp_v = exp_q.pop_front();
      checks++;
      if (status_out !== VALID || data_out !== exp_v) begin
        errors++;
        $display("[TB] FAIL b2b_single: beat %0d got status %0d data %0d expected status 1 data %0d", k, status_out, data_out, exp_v);
      end
    end
    grp_num = 8'd2;
    for (int k = 1; k <= 4; k++) begin
      drive_beat(k);
      if (k == 2) exp_q.push_back(DW'(3));
      if (k == 4) exp_q.push_back(DW'(7));
      step();
      if (k % 2 == 0) begin
        exp_v = exp_q.pop_front();
        checks++;
        if (status_out !== VALID || data_out !== exp_v) begin
          errors++;
          $display("[TB] FAIL b2b_pair: beat %0d got status %0d data %0d expected status 1 data %0d", k, status_out, data_out, exp_v);
        end
      end else begin
        checks++;
        if (status_out !== INVALID) begin
          errors++;
          $display("[TB] FAIL b2b_pair_gap: beat %0d got %0d expected %0d", k, status_out, INVALID);
        end
      end
    end
    drive_idle();
    step();
  endtask

  initial begin
    reset     = 1'b1;
    status_in = INVALID;
    data_in   = '0;
    grp_num   = '0;
    out_ready = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_single();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    test_random_gaps();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
